// File: rtl/proc_control_unit.sv
// proc_control_unit: multicycle control FSM for the 16-bit simple processor.
// Decodes the IR and sequences register/A/G/IR enables for mv, mvi, add, sub.
// Optional macro CTRL_AND_OP_EN: opcode 100 becomes 'and' (sequenced like add,
// alu_op=10). Without it opcode 100 is treated as illegal.
// Outputs are combinational from state and ir (and run in T0); reset blanks them.
module proc_control_unit #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [WIDTH-1:0] ir,
   output logic             ir_in,
   output logic [NREG-1:0]  r_in,
   output logic [NREG-1:0]  r_out,
   output logic             a_in,
   output logic             g_in,
   output logic             g_out,
   output logic             din_out,
   output logic [1:0]       alu_op,
   output logic             done
);

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
`ifdef CTRL_AND_OP_EN
   localparam logic [2:0] OP_AND = 3'b100;
`endif

   state_t          state_q, state_d;
   logic [2:0]      opcode, rx, ry;
   logic [NREG-1:0] rx_oh, ry_oh;
   logic            is_alu;
   logic [1:0]      alu_fn;

   assign opcode = ir[WIDTH-1 -: 3];
   assign rx     = ir[WIDTH-4 -: 3];
   assign ry     = ir[WIDTH-7 -: 3];
   assign rx_oh  = NREG'(1) << rx;
   assign ry_oh  = NREG'(1) << ry;

   // Bits below the register fields carry no control information.
   generate
      if (WIDTH > 9) begin : g_unused
         logic unused_ir_low;
         assign unused_ir_low = ^ir[WIDTH-10:0];
      end
   endgenerate

   // Classify the opcode: three-cycle ALU instructions and their ALU function.
   always_comb begin
      is_alu = 1'b0;
      alu_fn = 2'b00;
      case (opcode)
         OP_ADD: is_alu = 1'b1;
         OP_SUB: begin
            is_alu = 1'b1;
            alu_fn = 2'b01;
         end
`ifdef CTRL_AND_OP_EN
         OP_AND: begin
            is_alu = 1'b1;
            alu_fn = 2'b10;
         end
`endif
         default: ;
      endcase
   end

   // Next-state: T0 waits for run; T1 either finishes or enters the ALU path.
   always_comb begin
      state_d = state_q;
      case (state_q)
         T0:      state_d = run ? T1 : T0;
         T1:      state_d = is_alu ? T2 : T0;
         T2:      state_d = T3;
         default: state_d = T0;
      endcase
   end

   // State register with synchronous reset back to idle.
   always_ff @(posedge clock) begin
      if (reset) state_q <= T0;
      else       state_q <= state_d;
   end

   // Output decode; everything held low while reset is asserted.
   always_comb begin
      ir_in   = 1'b0;
      r_in    = '0;
      r_out   = '0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      g_out   = 1'b0;
      din_out = 1'b0;
      alu_op  = 2'b00;
      done    = 1'b0;
      if (!reset) begin
         case (state_q)
            T0: ir_in = run;
            T1: begin
               if (opcode == OP_MV) begin
                  r_out = ry_oh;
                  r_in  = rx_oh;
                  done  = 1'b1;
               end else if (opcode == OP_MVI) begin
                  din_out = 1'b1;
                  r_in    = rx_oh;
                  done    = 1'b1;
               end else if (is_alu) begin
                  r_out = rx_oh;
                  a_in  = 1'b1;
               end else begin
                  // Illegal opcode: retire immediately with no side effects.
                  done = 1'b1;
               end
            end
            T2: begin
               r_out  = ry_oh;
               g_in   = 1'b1;
               alu_op = alu_fn;
            end
            default: begin
               g_out = 1'b1;
               r_in  = rx_oh;
               done  = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: directed literal checks followed by random
// traffic compared every cycle against a queue-of-expected-cycles model.
module tb_proc_control_unit;

   typedef struct packed {
      logic       ir_in;
      logic [7:0] r_in;
      logic [7:0] r_out;
      logic       a_in;
      logic       g_in;
      logic       g_out;
      logic       din_out;
      logic [1:0] alu_op;
      logic       done;
   } outs_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        run   = 1'b0;
   logic [15:0] ir    = '0;
   logic        ir_in, a_in, g_in, g_out, din_out, done;
   logic [7:0]  r_in, r_out;
   logic [1:0]  alu_op;
   outs_t       dut_o;

   int checks = 0;
   int errors = 0;

   outs_t exp_q[$];   // expected outputs of the instruction cycles still to come

   proc_control_unit #(.WIDTH(16), .NREG(8)) dut (
      .clock(clock), .reset(reset), .run(run), .ir(ir),
      .ir_in(ir_in), .r_in(r_in), .r_out(r_out), .a_in(a_in), .g_in(g_in),
      .g_out(g_out), .din_out(din_out), .alu_op(alu_op), .done(done)
   );

   assign dut_o = {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, alu_op, done};

   always #5 clock = ~clock;

   function automatic outs_t mk(logic iri, logic [7:0] ri, logic [7:0] ro, logic ai,
                                logic gi, logic go, logic dn, logic [1:0] op, logic dne);
      outs_t o;
      o = {iri, ri, ro, ai, gi, go, dn, op, dne};
      return o;
   endfunction

   task automatic chk(input string name, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // An accepted instruction becomes a list of per-cycle expected outputs.
   function automatic void accept(logic [15:0] w);
      logic [2:0] op, rx, ry;
      logic [7:0] bx, by;
      logic [1:0] fn;
      bit         alu;
      op = w[15:13]; rx = w[12:10]; ry = w[9:7];
      bx = 8'(1) << rx; by = 8'(1) << ry;
      alu = (op == 3'd2) || (op == 3'd3);
      fn  = (op == 3'd3) ? 2'b01 : 2'b00;
`ifdef CTRL_AND_OP_EN
      if (op == 3'd4) begin alu = 1'b1; fn = 2'b10; end
`endif
      if (op == 3'd0)      exp_q.push_back(mk(0, bx, by, 0, 0, 0, 0, 2'b00, 1));
      else if (op == 3'd1) exp_q.push_back(mk(0, bx, 8'h00, 0, 0, 0, 1, 2'b00, 1));
      else if (alu) begin
         exp_q.push_back(mk(0, 8'h00, bx, 1, 0, 0, 0, 2'b00, 0));
         exp_q.push_back(mk(0, 8'h00, by, 0, 1, 0, 0, fn, 0));
         exp_q.push_back(mk(0, bx, 8'h00, 0, 0, 1, 0, 2'b00, 1));
      end else             exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1));
   endfunction

   // One clock cycle: drive after the edge, compare at the falling edge, then
   // advance the model to what the coming rising edge will do.
   task automatic step(input logic rst, input logic rn, input logic [15:0] w);
      outs_t e;
      @(posedge clock); #1;
      reset = rst; run = rn; ir = w;
      @(negedge clock);
      if (rst)                  e = '0;
      else if (exp_q.size() > 0) e = exp_q[0];
      else                      e = mk(rn, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
      chk("model", dut_o, e);
      checks++;
      if (($countones(r_out) + int'(g_out) + int'(din_out)) > 1 || !$onehot0(r_in)
          || !$onehot0(r_out)) begin
         errors++;
         $display("FAIL bus_invariant: r_in=%h r_out=%h g_out=%b din_out=%b required one-hot/single driver",
                  r_in, r_out, g_out, din_out);
      end
      if (rst) exp_q.delete();
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
      else if (rn) accept(w);
   endtask

   initial begin
      logic [15:0] cur;
      logic        r;
      // Reset with run held high.
      step(1, 1, 16'h0A80); chk("reset_c0", dut_o, '0);
      step(1, 1, 16'h0A80); chk("reset_c1", dut_o, '0);
      step(0, 1, 16'h0A80); chk("first_fetch", dut_o, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
      // mv R2,R5
      step(0, 0, 16'h0A80); chk("mv_t1", dut_o, mk(0, 8'h04, 8'h20, 0, 0, 0, 0, 2'b00, 1));
      step(0, 0, 16'h0A80); chk("mv_idle", dut_o, '0);
      // mvi R3
      step(0, 1, 16'h2C00);
      step(0, 0, 16'h2C00); chk("mvi_t1", dut_o, mk(0, 8'h08, 8'h00, 0, 0, 0, 1, 2'b00, 1));
      // add R1,R4
      step(0, 1, 16'h4600);
      step(0, 0, 16'h4600); chk("add_t1", dut_o, mk(0, 8'h00, 8'h02, 1, 0, 0, 0, 2'b00, 0));
      step(0, 0, 16'h4600); chk("add_t2", dut_o, mk(0, 8'h00, 8'h10, 0, 1, 0, 0, 2'b00, 0));
      step(0, 0, 16'h4600); chk("add_t3", dut_o, mk(0, 8'h02, 8'h00, 0, 0, 1, 0, 2'b00, 1));
      // sub R7,R0 with run held: next fetch immediately follows done
      step(0, 1, 16'h7C00);
      step(0, 1, 16'h7C00); chk("sub_t1", dut_o, mk(0, 8'h00, 8'h80, 1, 0, 0, 0, 2'b00, 0));
      step(0, 1, 16'h7C00); chk("sub_t2", dut_o, mk(0, 8'h00, 8'h01, 0, 1, 0, 0, 2'b01, 0));
      step(0, 1, 16'h7C00); chk("sub_t3", dut_o, mk(0, 8'h80, 8'h00, 0, 0, 1, 0, 2'b00, 1));
      step(0, 0, 16'h4600); chk("b2b_idle", dut_o, '0);
      // Abort add in T2
      step(0, 1, 16'h4600);
      step(0, 0, 16'h4600);
      step(1, 0, 16'h4600); chk("abort_t2", dut_o, '0);
      step(0, 0, 16'h4600); chk("abort_after", dut_o, '0);
      // Illegal opcode
      step(0, 1, 16'hE000);
      step(0, 0, 16'hE000); chk("illegal_t1", dut_o, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1));
      // and R2,R3
      step(0, 1, 16'h8980);
`ifdef CTRL_AND_OP_EN
      step(0, 0, 16'h8980); chk("and_t1", dut_o, mk(0, 8'h00, 8'h04, 1, 0, 0, 0, 2'b00, 0));
      step(0, 0, 16'h8980); chk("and_t2", dut_o, mk(0, 8'h00, 8'h08, 0, 1, 0, 0, 2'b10, 0));
      step(0, 0, 16'h8980); chk("and_t3", dut_o, mk(0, 8'h04, 8'h00, 0, 0, 1, 0, 2'b00, 1));
`else
      step(0, 0, 16'h8980); chk("and_illegal_t1", dut_o, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1));
`endif
      // Random traffic; ir only changes while no instruction is in flight.
      cur = 16'h0000;
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 29) == 0);
         if (exp_q.size() == 0) cur = 16'($urandom);
         step(r, ($urandom_range(0, 3) != 0), cur);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
- Multicycle control FSM for the 16-bit simple processor.
- Decodes the instruction word held in the IR and sequences register-file traffic for mv, mvi, add and sub (plus optional and).
- Drives the per-register load enables, the bus-source selects, the ALU op and done.
- Sits directly upstream of the register file, A, G and IR registers; its enables feed their enable inputs.

Parameters:
- WIDTH, 16, instruction/data word width; must be >= 9.
- NREG, 8, number of general registers; fixed at 8 because register fields are 3 bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  start request; sampled only in state T0.
- ir  in  WIDTH  current IR contents. opcode=ir[WIDTH-1:WIDTH-3], rx=ir[WIDTH-4:WIDTH-6], ry=ir[WIDTH-7:WIDTH-9].
- ir_in  out  1  IR load enable.
- r_in  out  NREG  one-hot register-file load enables.
- r_out  out  NREG  one-hot register-to-bus select.
- a_in  out  1  A register load enable.
- g_in  out  1  G register load enable.
- g_out  out  1  G-to-bus select.
- din_out  out  1  external din-to-bus select.
- alu_op  out  2  ALU function: 00 add, 01 sub, 10 and.
- done  out  1  one-cycle pulse marking the final cycle of an instruction.

Behaviour:
- States: T0, T1, T2, T3. State register is 2 bits.
- Outputs are combinational from state and ir (plus run in T0).
- All outputs are 0 unless explicitly asserted below; alu_op defaults to 00.
- Reset:
  - reset=1 at a clock edge forces state to T0.
  - While reset=1, every output is forced to 0, including ir_in.
  - Reset mid-instruction aborts it: no done pulse is issued and no further enables are asserted.
- T0 (idle/fetch):
  - ir_in = run.
  - If run=1, go to T1; otherwise stay in T0.
- T1, by opcode:
  - 000 mv: r_out[ry]=1, r_in[rx]=1, done=1; go to T0.
  - 001 mvi: din_out=1, r_in[rx]=1, done=1; go to T0. The immediate must be on din during T1.
  - 010 add / 011 sub: r_out[rx]=1, a_in=1; go to T2.
  - Any other opcode (illegal): no enables, done=1; go to T0.
- T2: r_out[ry]=1, g_in=1, alu_op=00 (add) or 01 (sub); go to T3.
- T3: g_out=1, r_in[rx]=1, done=1; go to T0.
- Latency, run-accept edge to done cycle:
  - mv, mvi, illegal: 1 cycle.
  - add, sub: 3 cycles.
- Invariants:
  - At most one of {r_out, g_out, din_out} is asserted in any cycle (single bus driver).
  - r_in and r_out are each one-hot or zero.
- run outside T0 is ignored; no queuing.
- Back-to-back operation: run=1 held continuously gives fetch in T0 immediately after done.
- rx==ry is legal. mv R,R reloads the same value; add R,R doubles it.
- ir must stay stable from T1 to T3. The unit does not re-latch it.

Optional Feature:
- Macro: CTRL_AND_OP_EN.
- Defined: opcode 100 = and, sequenced exactly like add with alu_op=10 in T2 (3 cycles to done).
- Undefined: opcode 100 is illegal, giving done in T1 with no enables, and alu_op never takes the value 10.

Test Plan:
- Reset: reset=1 for 2 cycles while run=1 -> every output 0 and state T0; the first run after release gives ir_in=1.
- mv R2,R5 (ir=0x0A80): one cycle after run -> T1 with r_out=8'b0010_0000, r_in=8'b0000_0100, done=1; next cycle is T0.
- mvi R3 (ir=0x2C00, din=0x1234): T1 -> din_out=1, r_in=8'b0000_1000, done=1, r_out=0.
- add R1,R4 (ir=0x4600):
  - T1: r_out=8'h02, a_in=1.
  - T2: r_out=8'h10, g_in=1, alu_op=00.
  - T3: g_out=1, r_in=8'h02, done=1.
  - sub R7,R0 (ir=0x7C00) gives the same sequence with alu_op=01 in T2.
- Abort and illegal:
  - Assert reset during T2 of add -> next cycle T0, all outputs 0, no done.
  - ir=0xE000 -> done in T1, with no enable asserted.
- Optional: ir=0x8980 (and R2,R3):
  - With CTRL_AND_OP_EN defined -> alu_op=10 in T2 and r_in=8'h04 in T3.
  - Without it -> done in T1 with no enables.
